// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, one-entry skid buffer
// and branch/jump redirect handling. Speaks a req/ack handshake to a
// variable-latency instruction memory.
module fetch_stage #(
    parameter int unsigned        INSTR_W  = 16,
    parameter int unsigned        ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [3:0]         ifid_opcode
);

    typedef enum logic [1:0] {StIdle, StFetch, StBuf, StDrop} state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
    logic [ADDR_W-1:0]    next_pc_q, next_pc_d;
    logic                 ifid_valid_q, ifid_valid_d;
    logic [INSTR_W-1:0]   ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]    ifid_pc_q, ifid_pc_d;
    logic                 buf_valid_q, buf_valid_d;
    logic [INSTR_W-1:0]   buf_instr_q, buf_instr_d;
    logic [ADDR_W-1:0]    buf_pc_q, buf_pc_d;

    logic consume;
    assign consume = ifid_valid_q && !stall;

    // Next-state, IF/ID and skid-buffer update; redirect takes priority.
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        next_pc_d    = next_pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        buf_valid_d  = buf_valid_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        imem_req     = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
                // next_pc must point past the first fetch address
                next_pc_d = req_addr_q + ADDR_W'(1);
                if (redirect_valid) begin
                    req_addr_d   = redirect_pc;
                    next_pc_d    = redirect_pc + ADDR_W'(1);
                    ifid_valid_d = 1'b0;
                    buf_valid_d  = 1'b0;
                end
            end
            StFetch: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    ifid_valid_d = 1'b0;
                    buf_valid_d  = 1'b0;
                    if (imem_ack) begin
                        req_addr_d = redirect_pc;
                        next_pc_d  = redirect_pc + ADDR_W'(1);
                    end else begin
                        // request in flight must still complete; drop its data
                        next_pc_d = redirect_pc;
                        state_d   = StDrop;
                    end
                end else if (imem_ack) begin
                    req_addr_d = next_pc_q;
                    next_pc_d  = next_pc_q + ADDR_W'(1);
                    if (!ifid_valid_q || !stall) begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = imem_rdata;
                        ifid_pc_d    = req_addr_q;
                    end else begin
                        buf_valid_d = 1'b1;
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = req_addr_q;
                        state_d     = StBuf;
                    end
                end else if (consume) begin
                    ifid_valid_d = 1'b0;
                end
            end
            StBuf: begin
                if (redirect_valid) begin
                    req_addr_d   = redirect_pc;
                    next_pc_d    = redirect_pc + ADDR_W'(1);
                    ifid_valid_d = 1'b0;
                    buf_valid_d  = 1'b0;
                    state_d      = StFetch;
                end else if (!stall) begin
                    ifid_valid_d = 1'b1;
                    ifid_instr_d = buf_instr_q;
                    ifid_pc_d    = buf_pc_q;
                    buf_valid_d  = 1'b0;
                    state_d      = StFetch;
                end
            end
            StDrop: begin
                imem_req     = 1'b1;
                ifid_valid_d = 1'b0;
                if (redirect_valid) begin
                    buf_valid_d = 1'b0;
                    if (imem_ack) begin
                        req_addr_d = redirect_pc;
                        next_pc_d  = redirect_pc + ADDR_W'(1);
                        state_d    = StFetch;
                    end else begin
                        next_pc_d = redirect_pc;
                    end
                end else if (imem_ack) begin
                    req_addr_d = next_pc_q;
                    next_pc_d  = next_pc_q + ADDR_W'(1);
                    state_d    = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; async reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            req_addr_q   <= RESET_PC;
            next_pc_q    <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
            buf_valid_q  <= 1'b0;
            buf_instr_q  <= '0;
            buf_pc_q     <= '0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            next_pc_q    <= next_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            buf_valid_q  <= buf_valid_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
        end
    end

    assign imem_addr   = req_addr_q;
    assign ifid_valid  = ifid_valid_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_pc     = ifid_pc_q;
    assign ifid_opcode = ifid_instr_q[INSTR_W-1 -: 4];

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register directly upstream of the decode/control unit.
- Drives the PC and a variable-latency instruction-memory request/ack handshake.
- Presents one instruction per cycle with its PC and 4-bit opcode to decode.
- Honours decode stalls through a one-entry skid buffer and handles branch/jump redirects from execute.

Parameters:
INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1:INSTR_W-4]
ADDR_W, 8, word-address width of PC and instruction memory
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  ADDR_W  request word address; stable while imem_req high
imem_rdata  in  INSTR_W  instruction, valid when imem_ack high
imem_ack  in  1  one-cycle pulse completing the outstanding request; never asserted without imem_req
stall  in  1  decode cannot accept; IF/ID must hold
redirect_valid  in  1  one-cycle pulse: taken BEQ or JMP
redirect_pc  in  ADDR_W  redirect target
ifid_valid  out  1  IF/ID holds a live instruction
ifid_instr  out  INSTR_W  registered instruction
ifid_pc  out  ADDR_W  address of ifid_instr
ifid_opcode  out  4  ifid_instr[INSTR_W-1:INSTR_W-4], drives the control unit opcode

Behaviour:
- Reset (async, rst_n low), all of the following:
  - state=IDLE, imem_req=0, req_addr=RESET_PC, next_pc=RESET_PC.
  - ifid_valid=0, ifid_instr=0, ifid_pc=0.
  - Buffer empty.
- Reset mid-transaction abandons any outstanding request. Memory must tolerate imem_req dropping.
- Registers: req_addr drives imem_addr; next_pc is the following fetch address.
- All increments are +1 modulo 2^ADDR_W (wrap 0xFF->0x00 at default).
- imem_req=1 in FETCH and DROP only.
- Consume: decode takes IF/ID on any edge where ifid_valid=1 and stall=0.
- States:
  - IDLE: next edge -> FETCH. Bubble only after reset.
  - FETCH, on ack with IF/ID free or being consumed (ifid_valid=0 or stall=0):
    - ifid_instr<=imem_rdata, ifid_pc<=req_addr, ifid_valid<=1.
    - req_addr<=next_pc, next_pc<=next_pc+1.
    - Stay in FETCH.
  - FETCH, on ack with ifid_valid=1 and stall=1:
    - Capture rdata/req_addr into the buffer.
    - req_addr<=next_pc, next_pc<=next_pc+1.
    - -> BUF.
  - FETCH, no ack: if IF/ID is consumed, ifid_valid<=0.
  - BUF: imem_req=0.
    - When stall=0: IF/ID<=buffer, buffer empty, -> FETCH.
    - While stall=1: IF/ID and buffer hold.
  - DROP: imem_req=1 with the stale req_addr held.
    - On ack: rdata discarded, req_addr<=next_pc, next_pc<=next_pc+1, -> FETCH.
    - ifid_valid stays 0.
- Redirect (redirect_valid=1) overrides stall and ack handling that cycle:
  - ifid_valid<=0 and buffer emptied. Stall is irrelevant, since the wrong-path instruction is squashed.
  - In FETCH without ack: next_pc<=redirect_pc, req_addr unchanged, -> DROP.
  - In FETCH with same-cycle ack: data discarded, req_addr<=redirect_pc, next_pc<=redirect_pc+1, stay in FETCH.
  - In BUF or IDLE: req_addr<=redirect_pc, next_pc<=redirect_pc+1, -> FETCH.
  - In DROP without ack: next_pc<=redirect_pc, stay in DROP.
  - In DROP with ack: req_addr<=redirect_pc, next_pc<=redirect_pc+1, -> FETCH.
- Latency: ack at edge N gives ifid_valid=1 after edge N, so the instruction is visible from cycle N+1.
- Throughput: one instruction per cycle with single-cycle ack.
- No instruction is ever lost or duplicated across stall, buffer or redirect.

Test Plan:
- Zero-wait memory (ack every cycle req is high), mem[a]=0x1000+a, stall=0 -> ifid_pc 0,1,2,3 on consecutive cycles, ifid_opcode=4'h1, first ifid_valid 2 cycles after rst_n rises.
- Stall held 3 cycles while IF/ID holds pc=2 and ack returns pc=3 -> state BUF, imem_req=0, IF/ID holds pc=2; on release IF/ID=pc 3, then pc 4 fetched; no gap, no duplicate.
- 3-cycle ack latency; redirect_valid to 0x40 one cycle after req for addr 5 issued -> DROP, addr 5 held until ack, data dropped, next imem_addr=0x40, ifid_pc sequence 0x40,0x41.
- Redirect to 0x10 coincident with ack while stall=1 and buffer full -> ifid_valid=0 next cycle, buffer empty, imem_addr=0x10, buffered instruction never appears.
- PC wrap: RESET_PC=0xFE -> ifid_pc 0xFE,0xFF,0x00.
- rst_n pulsed low mid-request in DROP -> imem_req=0 and ifid_valid=0 immediately (async); fetch restarts at RESET_PC.
